// File: rtl/fp_seq_multiplier.sv
// Iterative IEEE-754 single-precision multiplier: 24 shift-add iterations,
// then a single normalise/round-to-nearest-even step. Fixed 25-edge latency.
module fp_seq_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] p
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_NORM = 2'd2;

   logic [1:0]  state_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [47:0] acc_reg;
   logic [4:0]  cnt_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [31:0] p_reg;

   logic [23:0] mant_a;
   logic [23:0] mant_b;
   logic [47:0] partial;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic        sign;
   logic [9:0]  exp_sum;
   logic [9:0]  exp_norm;
   logic [9:0]  exp_final;
   logic [22:0] frac_pre;
   logic [23:0] frac_rnd;
   logic [22:0] frac_final;
   logic        guard;
   logic        sticky;
   logic        round_up;
   logic [31:0] result_next;

   assign mant_a  = {1'b1, a_reg[22:0]};
   assign mant_b  = {1'b1, b_reg[22:0]};
   assign exp_a   = a_reg[30:23];
   assign exp_b   = b_reg[30:23];
   assign sign    = a_reg[31] ^ b_reg[31];
   assign partial = {24'd0, mant_a} << cnt_reg;
   // Biased sum kept in 10 bits so it can be read as signed for under/overflow
   assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;

   always_comb begin
      frac_pre = acc_reg[45:23];
      guard    = acc_reg[22];
      sticky   = |acc_reg[21:0];
      exp_norm = exp_sum;
      if (acc_reg[47]) begin
         frac_pre = acc_reg[46:24];
         guard    = acc_reg[23];
         sticky   = |acc_reg[22:0];
         exp_norm = exp_sum + 10'd1;
      end
   end

   assign round_up   = guard & (sticky | frac_pre[0]);
   assign frac_rnd   = {1'b0, frac_pre} + {23'd0, round_up};
   assign exp_final  = exp_norm + {9'd0, frac_rnd[23]};
   assign frac_final = frac_rnd[23] ? 23'd0 : frac_rnd[22:0];

   always_comb begin
      result_next = {sign, exp_final[7:0], frac_final};
      if ((exp_a == 8'hFF && exp_b == 8'h00) || (exp_b == 8'hFF && exp_a == 8'h00)) begin
         result_next = 32'h7FC0_0000;
      end else if (exp_a == 8'hFF || exp_b == 8'hFF) begin
         result_next = {sign, 8'hFF, 23'd0};
      end else if (exp_a == 8'h00 || exp_b == 8'h00) begin
         result_next = {sign, 31'd0};
      end else if ($signed(exp_final) >= $signed(10'd255)) begin
         result_next = {sign, 8'hFF, 23'd0};
      end else if ($signed(exp_final) <= $signed(10'd0)) begin
         result_next = {sign, 31'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         acc_reg   <= 48'd0;
         cnt_reg   <= 5'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         p_reg     <= 32'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  acc_reg   <= 48'd0;
                  cnt_reg   <= 5'd0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (mant_b[cnt_reg]) begin
                  acc_reg <= acc_reg + partial;
               end
               cnt_reg <= cnt_reg + 5'd1;
               if (cnt_reg == 5'd23) begin
                  state_reg <= ST_NORM;
               end
            end
            ST_NORM: begin
               p_reg     <= result_next;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign p    = p_reg;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Self-checking bench for fp_seq_multiplier: directed table, random sweep
// against an arithmetic RNE model, handshake and mid-operation reset sequences.
module tb_fp_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] p;

   int n_chk;
   int n_err;

   fp_seq_multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   // Reference: exact integer product, then round to nearest-even by remainder comparison
   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic              s;
      int                ex;
      int                ey;
      int                e;
      int                sh;
      longint unsigned   mx;
      longint unsigned   my;
      longint unsigned   prod;
      longint unsigned   q;
      longint unsigned   rem;
      longint unsigned   half;
      logic [31:0]       r;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return 32'h7FC0_0000;
      if (ex == 255 || ey == 255) return {s, 8'hFF, 23'd0};
      if (ex == 0 || ey == 0) return {s, 31'd0};
      mx   = 64'h80_0000 + longint'(x[22:0]);
      my   = 64'h80_0000 + longint'(y[22:0]);
      prod = mx * my;
      e    = ex + ey - 127;
      if (prod >= (64'd1 << 47)) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      r = {s, 8'(e), q[22:0]};
      return r;
   endfunction

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Issue one operation from a post-edge point; returns result and edges from capture to done
   task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] got, output int lat, output logic hs_ok);
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      hs_ok = (busy === 1'b1) && (done === 1'b0);
      lat = 0;
      got = 32'hDEAD_BEEF;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1 && done === 1'b1) hs_ok = 1'b0;
         if (done === 1'b1) begin
            lat = i;
            got = p;
            break;
         end
         if (busy !== 1'b1) hs_ok = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_normal();
      logic [31:0] v;
      v = $urandom;
      v[30:23] = 8'($urandom_range(64, 189));
      return v;
   endfunction

   initial begin
      logic [31:0] got;
      logic [31:0] exp;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] last_p;
      logic [31:0] hp1;
      logic [31:0] hp2;
      logic [31:0] hp3;
      logic        hs_ok;
      logic        lat_ok;
      logic        stable_ok;
      logic        edge_ok;
      int          lat;
      int          pulses;

      n_chk = 0;
      n_err = 0;
      vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      vecs[1]  = '{32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000};
      vecs[2]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002};
      vecs[3]  = '{32'h3FC0_0001, 32'h3FFF_FFFE, 32'h403F_FFFF};
      vecs[4]  = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002};
      vecs[5]  = '{32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004};
      vecs[6]  = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000};
      vecs[7]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000};
      vecs[8]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000};
      vecs[9]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
      vecs[10] = '{32'hFFC0_0000, 32'h3F80_0000, 32'hFF80_0000};
      vecs[11] = '{32'h8000_0001, 32'hC000_0000, 32'h0000_0000};

      rst_n = 1'b0;
      start = 1'b0;
      a = 32'd0;
      b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_done", {31'd0, done}, 32'd0);
      check32("reset_p", p, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].b, got, lat, hs_ok);
         $display("vec %0d: a=%h b=%h p=%h lat=%0d", i, vecs[i].a, vecs[i].b, got, lat);
         check32($sformatf("vec%0d_p", i), got, vecs[i].exp);
         check32($sformatf("vec%0d_latency", i), 32'(lat), 32'd25);
         check32($sformatf("vec%0d_handshake", i), {31'd0, hs_ok}, 32'd1);
      end

      lat_ok = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (i % 4 == 3) begin
            ra = $urandom;
            rb = rand_normal();
            if ($urandom_range(0, 1) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         end else begin
            ra = rand_normal();
            rb = rand_normal();
         end
         exp = ref_mul(ra, rb);
         run_op(ra, rb, got, lat, hs_ok);
         $display("rnd %0d: a=%h b=%h p=%h exp=%h", i, ra, rb, got, exp);
         check32($sformatf("rnd%0d_p", i), got, exp);
         if (lat != 25 || !hs_ok) lat_ok = 1'b0;
      end
      check32("rnd_latency_handshake", {31'd0, lat_ok}, 32'd1);

      // start held high: captures at E0, E26, E52; operand A changes after first capture
      a = 32'h3FC0_0000;
      b = 32'hC000_0000;
      start = 1'b1;
      last_p = p;
      pulses = 0;
      stable_ok = 1'b1;
      edge_ok = 1'b1;
      hp1 = 32'd0;
      hp2 = 32'd0;
      hp3 = 32'd0;
      for (int n = 0; n <= 77; n++) begin
         @(posedge clk);
         #1;
         if (n == 2) a = 32'h4000_0000;
         if (n == 77) start = 1'b0;
         if (busy === 1'b1 && done === 1'b1) stable_ok = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            if (n == 25) hp1 = p;
            else if (n == 51) hp2 = p;
            else if (n == 77) hp3 = p;
            else edge_ok = 1'b0;
            last_p = p;
         end else if (p !== last_p) begin
            stable_ok = 1'b0;
         end
      end
      $display("handshake: pulses=%0d p1=%h p2=%h p3=%h", pulses, hp1, hp2, hp3);
      check32("hs_pulses", 32'(pulses), 32'd3);
      check32("hs_edges", {31'd0, edge_ok}, 32'd1);
      check32("hs_p1", hp1, 32'hC040_0000);
      check32("hs_p2", hp2, 32'hC080_0000);
      check32("hs_p3", hp3, 32'hC080_0000);
      check32("hs_stable", {31'd0, stable_ok}, 32'd1);

      // Abort an operation with reset at E10
      a = 32'h3F80_0000;
      b = 32'h4040_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("midreset: busy=%b done=%b p=%h", busy, done, p);
      check32("midrst_busy", {31'd0, busy}, 32'd0);
      check32("midrst_done", {31'd0, done}, 32'd0);
      check32("midrst_p", p, 32'd0);
      run_op(32'h3F80_0000, 32'h4040_0000, got, lat, hs_ok);
      $display("post-reset op: p=%h lat=%0d", got, lat);
      check32("midrst_next_p", got, 32'h4040_0000);
      check32("midrst_next_latency", 32'(lat), 32'd25);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
